// File: rtl/config_ctrl_pkg.sv
// Shared types and constants for the time-setting configuration controller:
// FSM state encoding, field indices, field limits and wrap-around step helpers.
package config_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EDIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int unsigned SM_W = 6;
    localparam int unsigned H_W  = 5;

    localparam logic [1:0] FIELD_S = 2'd0;
    localparam logic [1:0] FIELD_M = 2'd1;
    localparam logic [1:0] FIELD_H = 2'd2;

    localparam logic [SM_W-1:0] MAX_SM = 6'd59;
    localparam logic [H_W-1:0]  MAX_H  = 5'd23;

    // One step on a seconds/minutes field, wrapping 59 <-> 0.
    function automatic logic [SM_W-1:0] step_sm(input logic [SM_W-1:0] v, input logic up);
        if (up) return (v == MAX_SM) ? '0 : v + 6'd1;
        return (v == '0) ? MAX_SM : v - 6'd1;
    endfunction

    // One step on the hours field, wrapping 23 <-> 0.
    function automatic logic [H_W-1:0] step_h(input logic [H_W-1:0] v, input logic up);
        if (up) return (v == MAX_H) ? '0 : v + 5'd1;
        return (v == '0) ? MAX_H : v - 5'd1;
    endfunction

endpackage

// File: rtl/config_ctrl_if.sv
// Bus between the button debouncers / RTC register block and config_ctrl.
// master = environment side (buttons, current time, write ack),
// slave  = controller side (edit registers, cursor, status, write request).
interface config_ctrl_if;
    import config_ctrl_pkg::*;

    logic            btn_cfg;
    logic            btn_der;
    logic            btn_izq;
    logic            btn_up;
    logic            btn_down;
    logic [SM_W-1:0] cur_s;
    logic [SM_W-1:0] cur_m;
    logic [H_W-1:0]  cur_h;
    logic            wr_ack;
    logic [SM_W-1:0] edit_s;
    logic [SM_W-1:0] edit_m;
    logic [H_W-1:0]  edit_h;
    logic [1:0]      dir;
    logic            cfg_active;
    logic            wr_req;

    modport master (
        output btn_cfg, btn_der, btn_izq, btn_up, btn_down,
        output cur_s, cur_m, cur_h, wr_ack,
        input  edit_s, edit_m, edit_h, dir, cfg_active, wr_req
    );

    modport slave (
        input  btn_cfg, btn_der, btn_izq, btn_up, btn_down,
        input  cur_s, cur_m, cur_h, wr_ack,
        output edit_s, edit_m, edit_h, dir, cfg_active, wr_req
    );

endinterface

// File: rtl/config_ctrl_cursor.sv
// Field cursor for the edit session: counts 0..2 with wrap in both
// directions; der wins over izq; held at 0 whenever not enabled.
module cfg_cursor
    import config_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       der_i,
    input  logic       izq_i,
    input  logic       en_i,
    output logic [1:0] dir_o
);

    logic [1:0] dir_q, dir_d;

    // Next cursor position: forced to seconds when disabled, else wrap-around move.
    always_comb begin
        dir_d = dir_q;
        if (!en_i) begin
            dir_d = FIELD_S;
        end else if (der_i) begin
            dir_d = (dir_q == FIELD_H) ? FIELD_S : dir_q + 2'd1;
        end else if (izq_i) begin
            dir_d = (dir_q == FIELD_S) ? FIELD_H : dir_q - 2'd1;
        end
    end

    // Cursor register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dir_q <= FIELD_S;
        else       dir_q <= dir_d;
    end

    assign dir_o = dir_q;

endmodule

// File: rtl/config_ctrl.sv
// Time-setting configuration controller: button presses drive an edit
// session (IDLE -> LOAD -> EDIT -> WRITE) over seconds/minutes/hours and the
// edited time is handed to the RTC with a req/ack handshake.
// Optional feature: define AUTO_REPEAT_EN for hold-to-repeat on up/down.
module config_ctrl
    import config_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2**28
`ifdef AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 50_000_000,
    parameter int unsigned REPEAT_PERIOD  = 10_000_000
`endif
) (
    input logic           clk,
    input logic           reset,
    config_ctrl_if.slave  bus
);

    state_t          state_q, state_d;
    logic [4:0]      hist_q;
    logic [4:0]      lvl, press;
    logic            p_cfg, p_der, p_izq, p_up, p_dn, any_press;
    logic            rep_up, rep_dn, rep_any;
    logic            up_ev, dn_ev;
    logic [31:0]     to_q, to_d;
    logic            timeout_hit;
    logic            cfg_active_q, wr_req_q;
    logic [SM_W-1:0] es_q, es_d, em_q, em_d;
    logic [H_W-1:0]  eh_q, eh_d;
    logic [1:0]      dir;
    logic            cur_en;

    // A press is a level seen high now but low on the previous edge.
    assign lvl       = {bus.btn_cfg, bus.btn_der, bus.btn_izq, bus.btn_up, bus.btn_down};
    assign press     = lvl & ~hist_q;
    assign p_cfg     = press[4];
    assign p_der     = press[3];
    assign p_izq     = press[2];
    assign p_up      = press[1];
    assign p_dn      = press[0];
    assign any_press = |press;

`ifdef AUTO_REPEAT_EN
    logic [31:0] hold_q, hold_d;
    logic        rep_phase_q, rep_phase_d;
    logic        rep_fire;

    // Hold counter: runs while exactly one of up/down is held in EDIT with no
    // new press; first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
    always_comb begin
        hold_d      = '0;
        rep_phase_d = 1'b0;
        rep_fire    = 1'b0;
        if (state_q == EDIT && (bus.btn_up ^ bus.btn_down) && !any_press) begin
            hold_d      = hold_q + 32'd1;
            rep_phase_d = rep_phase_q;
            if (hold_d == (rep_phase_q ? REPEAT_PERIOD : REPEAT_DELAY)) begin
                rep_fire    = 1'b1;
                hold_d      = '0;
                rep_phase_d = 1'b1;
            end
        end
    end

    // Hold counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign rep_up = rep_fire & bus.btn_up;
    assign rep_dn = rep_fire & bus.btn_down;
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign rep_any     = rep_up | rep_dn;
    assign up_ev       = p_up | rep_up;
    assign dn_ev       = p_dn | rep_dn;
    assign timeout_hit = (state_q == EDIT) && !any_press && !rep_any &&
                         (to_q == TIMEOUT_CYCLES - 32'd1);

    // Next-state logic for the edit session.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (p_cfg) state_d = LOAD;
            LOAD:    state_d = EDIT;
            EDIT: begin
                if (p_cfg)            state_d = WRITE;
                else if (timeout_hit) state_d = IDLE;
            end
            WRITE:   if (bus.wr_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Inactivity counter: counts quiet EDIT cycles, reloads on any activity.
    always_comb begin
        to_d = '0;
        if (state_q == EDIT && !any_press && !rep_any && !timeout_hit)
            to_d = to_q + 32'd1;
    end

    // State, Moore outputs, button history and inactivity counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cfg_active_q <= 1'b0;
            wr_req_q     <= 1'b0;
            hist_q       <= '0;
            to_q         <= '0;
        end else begin
            state_q      <= state_d;
            cfg_active_q <= (state_d != IDLE);
            wr_req_q     <= (state_d == WRITE);
            hist_q       <= lvl;
            to_q         <= to_d;
        end
    end

    // The cursor only moves on edges that stay within EDIT; elsewhere it sits at seconds.
    assign cur_en = (state_q == EDIT) && (state_d == EDIT);

    cfg_cursor u_cursor (
        .clk   (clk),
        .reset (reset),
        .der_i (p_der),
        .izq_i (p_izq),
        .en_i  (cur_en),
        .dir_o (dir)
    );

    // Edit registers: loaded from the clock in LOAD, stepped at the current cursor in EDIT.
    always_comb begin
        es_d = es_q;
        em_d = em_q;
        eh_d = eh_q;
        if (state_q == LOAD) begin
            es_d = bus.cur_s;
            em_d = bus.cur_m;
            eh_d = bus.cur_h;
        end else if (state_q == EDIT && !p_cfg && (up_ev ^ dn_ev)) begin
            case (dir)
                FIELD_S: es_d = step_sm(es_q, up_ev);
                FIELD_M: em_d = step_sm(em_q, up_ev);
                FIELD_H: eh_d = step_h(eh_q, up_ev);
                default: ;
            endcase
        end
    end

    // Edit register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_q <= '0;
            em_q <= '0;
            eh_q <= '0;
        end else begin
            es_q <= es_d;
            em_q <= em_d;
            eh_q <= eh_d;
        end
    end

    assign bus.edit_s     = es_q;
    assign bus.edit_m     = em_q;
    assign bus.edit_h     = eh_q;
    assign bus.dir        = dir;
    assign bus.cfg_active = cfg_active_q;
    assign bus.wr_req     = wr_req_q;

endmodule

// File: tb/tb_config_ctrl.sv
// Self-checking bench for config_ctrl: directed button sequences, a
// behavioural model of the edit session compared every cycle, and
// hand-computed expectations at key points.
module tb_config_ctrl;

    localparam int T = 16;
    localparam int D = 8;
    localparam int P = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    config_ctrl_if bus();

    config_ctrl #(
        .TIMEOUT_CYCLES(T)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY(D),
        .REPEAT_PERIOD(P)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: state 0 idle, 1 load, 2 edit, 3 write; fields indexed s, m, h.
    int       m_state = 0;
    int       m_dir   = 0;
    int       m_quiet = 0;
    int       m_hold  = 0;
    int       m_f[3]  = '{0, 0, 0};
    bit [4:0] m_prev  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = 0;
        m_dir   = 0;
        m_quiet = 0;
        m_hold  = 0;
        m_f     = '{0, 0, 0};
        m_prev  = '0;
    endtask

    task automatic m_step();
        bit [4:0] lv, pr;
        bit       anyp, rep, u, d;
        int       mx;
        lv   = {bus.btn_cfg, bus.btn_der, bus.btn_izq, bus.btn_up, bus.btn_down};
        pr   = lv & ~m_prev;
        anyp = |pr;
        if (m_state == 2 && (bus.btn_up ^ bus.btn_down) && !anyp) m_hold++;
        else m_hold = 0;
        rep = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep = (m_hold >= D) && (((m_hold - D) % P) == 0);
`endif
        case (m_state)
            0: if (pr[4]) m_state = 1;
            1: begin
                m_f[0]  = int'(bus.cur_s);
                m_f[1]  = int'(bus.cur_m);
                m_f[2]  = int'(bus.cur_h);
                m_state = 2;
            end
            2: begin
                if (pr[4]) begin
                    m_state = 3;
                end else begin
                    u  = pr[1] | (rep & bus.btn_up);
                    d  = pr[0] | (rep & bus.btn_down);
                    mx = (m_dir == 2) ? 24 : 60;
                    if (u && !d) m_f[m_dir] = (m_f[m_dir] + 1) % mx;
                    if (d && !u) m_f[m_dir] = (m_f[m_dir] + mx - 1) % mx;
                    if (pr[3])      m_dir = (m_dir + 1) % 3;
                    else if (pr[2]) m_dir = (m_dir + 2) % 3;
                    if (anyp || rep) m_quiet = 0;
                    else begin
                        m_quiet++;
                        if (m_quiet == T) m_state = 0;
                    end
                end
            end
            default: if (bus.wr_ack) m_state = 0;
        endcase
        if (m_state != 2) begin
            m_dir   = 0;
            m_quiet = 0;
        end
        m_prev = lv;
    endtask

    // Compare process: advance the model at each rising edge, compare mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) m_reset();
            else       m_step();
            @(negedge clk);
            if (reset) m_reset();
            check("edit_s",     bus.edit_s,     m_f[0]);
            check("edit_m",     bus.edit_m,     m_f[1]);
            check("edit_h",     bus.edit_h,     m_f[2]);
            check("dir",        bus.dir,        m_dir);
            check("cfg_active", bus.cfg_active, m_state != 0);
            check("wr_req",     bus.wr_req,     m_state == 3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_btns(input bit c, input bit r, input bit l, input bit u, input bit n);
        bus.btn_cfg  = c;
        bus.btn_der  = r;
        bus.btn_izq  = l;
        bus.btn_up   = u;
        bus.btn_down = n;
    endtask

    task automatic press(input bit c, input bit r, input bit l, input bit u, input bit n);
        set_btns(c, r, l, u, n);
        tick();
        set_btns(0, 0, 0, 0, 0);
        tick();
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        set_btns(0, 0, 0, 0, 0);
        bus.cur_s  = 6'd58;
        bus.cur_m  = 6'd59;
        bus.cur_h  = 5'd23;
        bus.wr_ack = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        check("rst_cfg_active", bus.cfg_active, 0);
        check("rst_wr_req",     bus.wr_req,     0);
        check("rst_dir",        bus.dir,        0);
        check("rst_edit_s",     bus.edit_s,     0);
        check("rst_edit_h",     bus.edit_h,     0);
        reset = 1'b0;
        tick();

        set_btns(1, 0, 0, 0, 0);
        tick();
        check("load_cfg_active", bus.cfg_active, 1);
        check("load_wr_req",     bus.wr_req,     0);
        set_btns(0, 0, 0, 0, 0);
        tick();
        check("edit_load_s", bus.edit_s, 58);
        check("edit_load_m", bus.edit_m, 59);
        check("edit_load_h", bus.edit_h, 23);
        check("edit_dir0",   bus.dir,    0);

        press(0, 0, 0, 1, 0);
        check("up_s59", bus.edit_s, 59);
        press(0, 0, 0, 1, 0);
        check("up_wrap_s0", bus.edit_s, 0);
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        check("der2_dir", bus.dir, 2);
        press(0, 0, 0, 1, 0);
        check("up_wrap_h0", bus.edit_h, 0);
        press(0, 0, 0, 0, 1);
        check("dn_wrap_h23", bus.edit_h, 23);
        press(0, 1, 0, 0, 0);
        check("der_wrap_dir0", bus.dir, 0);
        press(0, 0, 1, 0, 0);
        check("izq_wrap_dir2", bus.dir, 2);
        press(0, 1, 1, 0, 0);
        check("der_beats_izq", bus.dir, 0);
        press(0, 0, 0, 1, 1);
        check("updown_nochange", bus.edit_s, 0);
        press(0, 1, 0, 1, 0);
        check("move_step_dir",     bus.dir,    1);
        check("move_step_old_dir", bus.edit_s, 1);

        // Hold up at the minutes field for the press edge plus 20 cycles.
        set_btns(0, 0, 0, 1, 0);
        repeat (21) tick();
`ifdef AUTO_REPEAT_EN
        check("repeat_edit_m",     bus.edit_m,     4);
        check("repeat_cfg_active", bus.cfg_active, 1);
`else
        check("hold_abort_idle",  bus.cfg_active, 0);
        check("hold_edit_m_kept", bus.edit_m,     0);
`endif
        set_btns(0, 0, 0, 0, 0);
        tick();
`ifndef AUTO_REPEAT_EN
        press(1, 0, 0, 0, 0);
`endif

        press(1, 0, 0, 1, 0);
        check("cfg_beats_up_wr_req", bus.wr_req, 1);
`ifdef AUTO_REPEAT_EN
        check("cfg_beats_up_field", bus.edit_s, 1);
`else
        check("cfg_beats_up_field", bus.edit_s, 58);
`endif
        repeat (5) begin
            tick();
            check("wr_ack_low_hold", bus.wr_req, 1);
        end
        bus.wr_ack = 1'b1;
        tick();
        check("ack_wr_req_drop", bus.wr_req,     0);
        check("ack_idle",        bus.cfg_active, 0);
        bus.wr_ack = 1'b0;

        // Inactivity abort.
        set_btns(1, 0, 0, 0, 0);
        tick();
        set_btns(0, 0, 0, 0, 0);
        tick();
        repeat (15) tick();
        check("timeout_still_edit", bus.cfg_active, 1);
        tick();
        check("timeout_abort",     bus.cfg_active, 0);
        check("timeout_no_wr_req", bus.wr_req,     0);

        // Reset while a write is pending.
        set_btns(1, 0, 0, 0, 0);
        tick();
        set_btns(0, 0, 0, 0, 0);
        tick();
        set_btns(1, 0, 0, 0, 0);
        tick();
        check("write_pending", bus.wr_req, 1);
        reset = 1'b1;
        set_btns(0, 0, 0, 0, 0);
        #1;
        check("rst_in_write_wr_req",     bus.wr_req,     0);
        check("rst_in_write_cfg_active", bus.cfg_active, 0);
        check("rst_in_write_edit_s",     bus.edit_s,     0);
        tick();
        tick();
        reset      = 1'b0;
        bus.wr_ack = 1'b1;
        repeat (3) tick();
        check("no_write_after_rst", bus.wr_req, 0);
        bus.wr_ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
